// File: rtl/sdram_page_arbiter.sv
// Round-robin arbiter that shares one SDRAM page-command port among several
// stream channels, each owning a circular region of pages.
module sdram_page_arbiter #(
  parameter int CHANNELS         = 2,
  parameter int SDRAM_ADDR_WIDTH = 15,
  localparam int PAGE_BITS       = SDRAM_ADDR_WIDTH - $clog2(CHANNELS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS-1:0]         ch_wr_req,
  input  logic [CHANNELS-1:0]         ch_rd_req,
  input  logic [CHANNELS-1:0]         ch_clear,
  output logic [CHANNELS-1:0]         ch_full,
  output logic [CHANNELS-1:0]         ch_empty,
  output logic [CHANNELS-1:0]         grant_wr,
  output logic [CHANNELS-1:0]         grant_rd,
  output logic [CHANNELS-1:0]         page_done,
  output logic                        sdram_cmd_wr,
  output logic                        sdram_cmd_rd,
  input  logic                        sdram_cmd_ack,
  input  logic                        sdram_cmd_done,
  output logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr
);

  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [PAGE_BITS:0]   CNT_ONE  = (PAGE_BITS + 1)'(1);
  localparam logic [PAGE_BITS:0]   CNT_FULL = CNT_ONE << PAGE_BITS;
  localparam logic [PAGE_BITS-1:0] PTR_ONE  = PAGE_BITS'(1);

  typedef enum logic [1:0] {IDLE, REQ, BUSY, UPDATE} state_e;

  state_e                      state_q, state_d;
  logic [CH_BITS-1:0]          last_q, last_d;
  logic [CH_BITS-1:0]          sel_q, sel_d;
  logic                        sel_wr_q, sel_wr_d;
  logic [SDRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CHANNELS-1:0]         clr_pend_q, clr_pend_d;
  logic [CHANNELS-1:0]         full_q, full_d;
  logic [CHANNELS-1:0]         empty_q, empty_d;
  logic [PAGE_BITS-1:0]        wr_ptr_q [CHANNELS];
  logic [PAGE_BITS-1:0]        wr_ptr_d [CHANNELS];
  logic [PAGE_BITS-1:0]        rd_ptr_q [CHANNELS];
  logic [PAGE_BITS-1:0]        rd_ptr_d [CHANNELS];
  logic [PAGE_BITS:0]          count_q  [CHANNELS];
  logic [PAGE_BITS:0]          count_d  [CHANNELS];

  logic [CHANNELS-1:0] wr_elig, rd_elig;
  logic                found, win_wr;
  logic [CH_BITS-1:0]  win, idx;
  logic [CHANNELS-1:0] sel_onehot;
  logic                busy_phase;

  // The channel index sits above the page pointer; with one channel the shift drops it.
  function automatic logic [SDRAM_ADDR_WIDTH-1:0] make_addr(input logic [CH_BITS-1:0] ch,
                                                            input logic [PAGE_BITS-1:0] ptr);
    return (SDRAM_ADDR_WIDTH'(ch) << PAGE_BITS) | SDRAM_ADDR_WIDTH'(ptr);
  endfunction

  always_comb begin
    wr_elig = ch_wr_req & ~full_q & ~ch_clear;
    rd_elig = ch_rd_req & ~empty_q & ~ch_clear;
    found   = 1'b0;
    win     = last_q;
    win_wr  = 1'b0;
    idx     = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = CH_BITS'((int'(last_q) + i) % CHANNELS);
      if (!found && (wr_elig[idx] || rd_elig[idx])) begin
        found  = 1'b1;
        win    = idx;
        win_wr = wr_elig[idx];
      end
    end
  end

  assign busy_phase = (state_q == REQ) || (state_q == BUSY);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    sel_wr_d   = sel_wr_q;
    addr_d     = addr_q;
    clr_pend_d = clr_pend_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    full_d     = full_q;
    empty_d    = empty_q;

    // A clear on the granted channel is deferred so the in-flight page finishes cleanly.
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_clear[c]) begin
        if (state_q != IDLE && sel_q == CH_BITS'(c)) begin
          if (busy_phase) clr_pend_d[c] = 1'b1;
        end else begin
          wr_ptr_d[c] = '0;
          rd_ptr_d[c] = '0;
          count_d[c]  = '0;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d    = win;
          sel_wr_d = win_wr;
          addr_d   = make_addr(win, win_wr ? wr_ptr_q[win] : rd_ptr_q[win]);
          state_d  = REQ;
        end
      end
      REQ: begin
        if (sdram_cmd_ack) state_d = sdram_cmd_done ? UPDATE : BUSY;
      end
      BUSY: begin
        if (sdram_cmd_done) state_d = UPDATE;
      end
      UPDATE: begin
        if (clr_pend_q[sel_q] || ch_clear[sel_q]) begin
          wr_ptr_d[sel_q] = '0;
          rd_ptr_d[sel_q] = '0;
          count_d[sel_q]  = '0;
        end else if (sel_wr_q) begin
          wr_ptr_d[sel_q] = wr_ptr_q[sel_q] + PTR_ONE;
          count_d[sel_q]  = count_q[sel_q] + CNT_ONE;
        end else begin
          rd_ptr_d[sel_q] = rd_ptr_q[sel_q] + PTR_ONE;
          count_d[sel_q]  = count_q[sel_q] - CNT_ONE;
        end
        clr_pend_d[sel_q] = 1'b0;
        last_d            = sel_q;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int c = 0; c < CHANNELS; c++) begin
      full_d[c]  = (count_d[c] == CNT_FULL);
      empty_d[c] = (count_d[c] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= CH_BITS'(CHANNELS - 1);
      sel_q      <= '0;
      sel_wr_q   <= 1'b0;
      addr_q     <= '0;
      clr_pend_q <= '0;
      full_q     <= '0;
      empty_q    <= '1;
      wr_ptr_q   <= '{default: '0};
      rd_ptr_q   <= '{default: '0};
      count_q    <= '{default: '0};
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      sel_wr_q   <= sel_wr_d;
      addr_q     <= addr_d;
      clr_pend_q <= clr_pend_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign sel_onehot   = CHANNELS'(1) << sel_q;
  assign grant_wr     = (busy_phase &&  sel_wr_q) ? sel_onehot : '0;
  assign grant_rd     = (busy_phase && !sel_wr_q) ? sel_onehot : '0;
  assign page_done    = (state_q == UPDATE) ? sel_onehot : '0;
  assign sdram_cmd_wr = (state_q == REQ) &&  sel_wr_q;
  assign sdram_cmd_rd = (state_q == REQ) && !sel_wr_q;
  assign sdram_addr   = addr_q;
  assign ch_full      = full_q;
  assign ch_empty     = empty_q;

endmodule
